// File: rtl/sample_format_pipe.sv
// sample_format_pipe
//   Multi-channel, two-stage sample-format converter that sits between the
//   ADC/DAC data path and the SPGD core. Each lane is converted between
//   two's-complement and offset-binary coding. It is also resized from
//   IN_WIDTH to OUT_WIDTH using round-half-up and saturation. Both sides use
//   valid/ready handshakes.
//
//   S1 = decode + round. S2 = saturate + encode.
//   Latency is 2 clk from accept to m_valid when unblocked.
//   Throughput is 1 beat/clk.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   mode      [0]=1 input is offset-binary, [1]=1 output is offset-binary
//   s_data    CHANNELS lanes of IN_WIDTH, lane k at [k*IN_WIDTH +: IN_WIDTH]
//   s_valid   input beat valid
//   s_ready   block can accept a beat this cycle
//   m_data    CHANNELS lanes of OUT_WIDTH, lane k at [k*OUT_WIDTH +: OUT_WIDTH]
//   m_valid   output beat valid
//   m_ready   sink accepts the beat
//   sat_flag  per-lane flag: the beat on m_data was clamped
//   sat_count (only with SAT_COUNT_EN) counts emitted beats that have any
//             sat_flag bit set; it holds at 16'hFFFF instead of wrapping
//
// Build option
//   SAT_COUNT_EN  adds the sat_count port and its counter

// One lane. It holds the S1 register (decoded and rounded, OUT_WIDTH+1 bits
// so that a positive overflow is still visible) and the S2 output register.
module sample_format_lane #(
  parameter int IN_WIDTH  = 14,
  parameter int OUT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_s1_ld,
  input  logic                 i_s2_ld,
  input  logic                 i_dec_ob,
  input  logic                 i_enc_ob,
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_sat
);
  localparam int D = IN_WIDTH - OUT_WIDTH;

  logic [IN_WIDTH-1:0]  w_dec;
  logic [OUT_WIDTH:0]   w_rnd;
  logic [OUT_WIDTH:0]   r_s1;
  logic                 w_ovf;
  logic [OUT_WIDTH-1:0] w_clamp;
  logic [OUT_WIDTH-1:0] w_enc;

  // Offset-binary to two's complement is an MSB flip.
  assign w_dec = {i_data[IN_WIDTH-1] ^ i_dec_ob, i_data[IN_WIDTH-2:0]};

  generate
    if (D > 0) begin : g_down
      localparam logic [IN_WIDTH:0] RND = (IN_WIDTH+1)'(1) << (D-1);
      logic [IN_WIDTH:0] w_sum;
      logic [D-1:0]      w_unused_frac;
      // Sign-extend by one bit so that +half cannot wrap. Taking bits [IN:D]
      // of the sum is the arithmetic shift right by D.
      assign w_sum = {w_dec[IN_WIDTH-1], w_dec} + RND;
      assign {w_rnd, w_unused_frac} = w_sum;
    end else if (D == 0) begin : g_pass
      assign w_rnd = {w_dec[IN_WIDTH-1], w_dec};
    end else begin : g_up
      localparam int UP = OUT_WIDTH - IN_WIDTH;
      assign w_rnd = {w_dec[IN_WIDTH-1], w_dec, {UP{1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)          r_s1 <= '0;
    else if (i_s1_ld) r_s1 <= w_rnd;
  end

  // The top two bits disagree only when rounding pushed a value past the
  // positive limit. The min branch is kept so that the clamp stays symmetric.
  assign w_ovf   = r_s1[OUT_WIDTH] ^ r_s1[OUT_WIDTH-1];
  assign w_clamp = w_ovf ? {r_s1[OUT_WIDTH], {(OUT_WIDTH-1){~r_s1[OUT_WIDTH]}}}
                         : r_s1[OUT_WIDTH-1:0];
  assign w_enc   = {w_clamp[OUT_WIDTH-1] ^ i_enc_ob, w_clamp[OUT_WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
      o_sat  <= 1'b0;
    end else if (i_s2_ld) begin
      o_data <= w_enc;
      o_sat  <= w_ovf;
    end
  end
endmodule

module sample_format_pipe #(
  parameter int IN_WIDTH  = 14,
  parameter int OUT_WIDTH = 12,
  parameter int CHANNELS  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic [CHANNELS*IN_WIDTH-1:0]  s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0] m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CHANNELS-1:0]           sat_flag
`ifdef SAT_COUNT_EN
  ,
  output logic [15:0]                   sat_count
`endif
);
  logic r_s1_valid;
  logic r_s1_enc_ob;
  logic w_s2_en;
  logic w_s1_en;
  logic w_acc;
  logic w_s2_ld;

  // A stage loads when it is empty or when its contents leave this cycle.
  assign w_s2_en = ~m_valid | m_ready;
  assign w_s1_en = ~r_s1_valid | w_s2_en;
  assign s_ready = w_s1_en;
  assign w_acc   = s_valid & w_s1_en;
  // S2 data moves only on a real beat. This keeps m_data frozen during a
  // stall, and also when S1 is empty.
  assign w_s2_ld = w_s2_en & r_s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_enc_ob <= 1'b0;
      m_valid     <= 1'b0;
    end else begin
      if (w_s1_en) r_s1_valid <= s_valid;
      if (w_acc)   r_s1_enc_ob <= mode[1];
      if (w_s2_en) m_valid <= r_s1_valid;
    end
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      sample_format_lane #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .i_s1_ld (w_acc),
        .i_s2_ld (w_s2_ld),
        .i_dec_ob(mode[0]),
        .i_enc_ob(r_s1_enc_ob),
        .i_data  (s_data[k*IN_WIDTH +: IN_WIDTH]),
        .o_data  (m_data[k*OUT_WIDTH +: OUT_WIDTH]),
        .o_sat   (sat_flag[k])
      );
    end
  endgenerate

`ifdef SAT_COUNT_EN
  // Count on the transfer edge only, so a stalled beat is counted once.
  always_ff @(posedge clk) begin
    if (rst)
      sat_count <= '0;
    else if (m_valid && m_ready && (|sat_flag) && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sample_format_pipe.sv
module tb_sample_format_pipe;
  localparam int IW = 14;
  localparam int OW = 12;
  localparam int CH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [CH*IW-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [CH*OW-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CH-1:0]    sat_flag;
`ifdef SAT_COUNT_EN
  logic [15:0]      sat_count;
`endif

  always #5 clk = ~clk;

  sample_format_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CHANNELS(CH)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .sat_flag(sat_flag)
`ifdef SAT_COUNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  typedef struct {
    logic [1:0]  mode;
    logic [13:0] l0;
    logic [13:0] l1;
    logic [11:0] e0;
    logic [11:0] e1;
    logic [1:0]  es;
  } vec_t;

  vec_t tv[10];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, oidx, occ;
    logic acc, emit, pstall;
    logic [CH*OW-1:0] pdata;

    // Hand-computed vectors for IN=14, OUT=12 (D=2, round = +2 then >>2)
    tv[0] = '{2'b10, 14'h0000, 14'h2000, 12'h800, 12'h000, 2'b00};
    tv[1] = '{2'b10, 14'h1FFF, 14'h0005, 12'hFFF, 12'h801, 2'b01};
    tv[2] = '{2'b01, 14'h2000, 14'h0000, 12'h000, 12'h800, 2'b00};
    tv[3] = '{2'b00, 14'h1FFE, 14'h0006, 12'h7FF, 12'h002, 2'b01}; // 8190+2 -> 2048 clamps
    tv[4] = '{2'b00, 14'h1FFD, 14'h3FFF, 12'h7FF, 12'h000, 2'b00}; // 8191>>2 = 2047 fits
    tv[5] = '{2'b00, 14'h3FFE, 14'h2001, 12'h000, 12'h800, 2'b00};
    tv[6] = '{2'b11, 14'h3FFF, 14'h0000, 12'hFFF, 12'h000, 2'b01};
    tv[7] = '{2'b00, 14'h1FFF, 14'h1FFF, 12'h7FF, 12'h7FF, 2'b11};
    tv[8] = '{2'b01, 14'h0001, 14'h2002, 12'h800, 12'h001, 2'b00};
    tv[9] = '{2'b00, 14'h0002, 14'h3FFD, 12'h001, 12'hFFF, 2'b00};

    rst = 1'b1; mode = 2'b00; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset m_valid", m_valid, 0);
    chk("reset s_ready", s_ready, 1);
    chk("reset m_data", m_data, 0);
    chk("reset sat_flag", sat_flag, 0);
`ifdef SAT_COUNT_EN
    chk("reset sat_count", sat_count, 0);
`endif

    // Single beats: latency, values, and mode captured with the beat
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mode = tv[i].mode; s_data = {tv[i].l1, tv[i].l0}; s_valid = 1'b1;
      #1 chk("vec s_ready", s_ready, 1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0; mode = ~tv[i].mode;
      #1 chk("vec lat1 m_valid", m_valid, 0);
      @(posedge clk);
      @(negedge clk); #1;
      chk("vec m_valid", m_valid, 1);
      chk($sformatf("vec%0d m_data", i), m_data, {tv[i].e1, tv[i].e0});
      chk($sformatf("vec%0d sat_flag", i), sat_flag, tv[i].es);
    end

    // Stream 8 beats with m_ready pattern 1,0,0,1
    idx = 0; oidx = 0; occ = 0; pstall = 1'b0; pdata = '0;
    for (int cyc = 0; cyc < 80 && oidx < 8; cyc++) begin
      @(negedge clk);
      m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      s_valid = (idx < 8);
      if (idx < 8) begin
        mode = tv[idx].mode; s_data = {tv[idx].l1, tv[idx].l0};
      end
      #1;
      if (pstall) begin
        chk("stall m_valid", m_valid, 1);
        chk("stall m_data stable", m_data, pdata);
      end
      chk("stream s_ready", s_ready, !(occ == 2 && !m_ready));
      acc  = s_valid && s_ready;
      emit = m_valid && m_ready;
      if (emit) begin
        chk($sformatf("stream%0d m_data", oidx), m_data, {tv[oidx].e1, tv[oidx].e0});
        chk($sformatf("stream%0d sat_flag", oidx), sat_flag, tv[oidx].es);
        oidx++;
      end
      pstall = m_valid && !m_ready;
      pdata  = m_data;
      @(posedge clk);
      occ = occ + int'(acc) - int'(emit);
      idx = idx + int'(acc);
    end
    chk("stream beats emitted", oidx, 8);

    // Reset with 2 beats in flight while a third beat is offered
    @(negedge clk);
    m_ready = 1'b0; s_valid = 1'b1; mode = tv[1].mode; s_data = {tv[1].l1, tv[1].l0};
    @(posedge clk);
    @(negedge clk);
    mode = tv[2].mode; s_data = {tv[2].l1, tv[2].l0};
    @(posedge clk);
    @(negedge clk); #1;
    chk("full s_ready", s_ready, 0);
    chk("full m_valid", m_valid, 1);
    rst = 1'b1; m_ready = 1'b1; mode = tv[3].mode; s_data = {tv[3].l1, tv[3].l0};
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    #1;
    chk("post-rst m_valid", m_valid, 0);
    chk("post-rst s_ready", s_ready, 1);
    chk("post-rst m_data", m_data, 0);
    chk("post-rst sat_flag", sat_flag, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      chk("post-rst no stale beat", m_valid, 0);
    end

`ifdef SAT_COUNT_EN
    chk("rst sat_count", sat_count, 0);
    @(negedge clk);
    m_ready = 1'b0; s_valid = 1'b1; mode = tv[1].mode; s_data = {tv[1].l1, tv[1].l0};
    @(posedge clk);
    @(negedge clk); s_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("cnt stalled m_valid", m_valid, 1);
    chk("cnt during stall", sat_count, 0);
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("cnt after stalled emit", sat_count, 1);
    foreach (tv[j]) begin
      if (j == 3 || j == 7 || j == 0) begin
        @(negedge clk);
        mode = tv[j].mode; s_data = {tv[j].l1, tv[j].l0}; s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); s_valid = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("cnt final", sat_count, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
